gen_tx_frame: RTL

- Parametrised MIL-STD-1553 transmit frame sequencer; successor to the single-window txen/DAT generator.
- On a start strobe it emits one command word followed by a programmable number of contiguous data words, then a mandatory bus-idle gap.
- Each word occupies a fixed window of clock cycles: txen, DAT and sync type are driven per word.
- Feeds the Manchester encoder/line driver; data words are fetched from an external async-read data buffer via dw_addr/dw_in.

---
 rtl/gen_tx_frame.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gen_tx_frame.sv
// MIL-STD-1553 transmit frame sequencer: one command word, N data words, then a forced bus-idle gap.
// Define ABORT_EN to add the abort input and aborted status output for early frame termination.
module gen_tx_frame #(
    parameter int unsigned WORD_CYC = 1000,
    parameter int unsigned GAP_CYC  = 200,
    parameter logic [15:0] CW_TX    = 16'hDEF0,
    parameter int unsigned MAX_DW   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        st,
`ifdef ABORT_EN
    input  logic                        abort,
    output logic                        aborted,
`endif
    input  logic [$clog2(MAX_DW)-1:0]   dw_cnt,
    input  logic [15:0]                 dw_in,
    output logic [$clog2(MAX_DW)-1:0]   dw_addr,
    output logic                        txen,
    output logic [15:0]                 DAT,
    output logic                        sync_cw,
    output logic                        word_stb,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned AW  = $clog2(MAX_DW);
    localparam int unsigned WcW = (WORD_CYC > 1) ? $clog2(WORD_CYC) : 1;
    localparam int unsigned GcW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [WcW-1:0] WcLast = WcW'(WORD_CYC - 1);
    localparam logic [GcW-1:0] GcLast = GcW'(GAP_CYC - 1);

    typedef enum logic [1:0] {StIdle, StCw, StDw, StGap} state_e;

    state_e          state_q, state_d;
    logic [WcW-1:0]  wc_q, wc_d;
    logic [GcW-1:0]  gc_q, gc_d;
    logic [AW-1:0]   kidx_q, kidx_d;
    logic [AW-1:0]   nlast_q, nlast_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     dat_q, dat_d;
    logic            abort_req;

`ifdef ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wc_q    <= '0;
            gc_q    <= '0;
            kidx_q  <= '0;
            nlast_q <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            gc_q    <= gc_d;
            kidx_q  <= kidx_d;
            nlast_q <= nlast_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        gc_d    = gc_q;
        kidx_d  = kidx_q;
        nlast_d = nlast_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        unique case (state_q)
            StIdle: begin
                if (st) begin
                    state_d = StCw;
                    wc_d    = '0;
                    kidx_d  = '0;
                    // dw_cnt=0 wraps to MAX_DW-1, i.e. a full MAX_DW-word frame
                    nlast_d = dw_cnt - AW'(1);
                    addr_d  = '0;
                end
            end
            StCw: begin
                if (abort_req) begin
                    state_d = StGap;
                    gc_d    = '0;
                end else if (wc_q == WcLast) begin
                    state_d = StDw;
                    wc_d    = '0;
                    kidx_d  = '0;
                    dat_d   = dw_in;
                    addr_d  = addr_q + AW'(1);
                end else begin
                    wc_d = wc_q + WcW'(1);
                end
            end
            StDw: begin
                if (abort_req) begin
                    state_d = StGap;
                    gc_d    = '0;
                end else if (wc_q == WcLast) begin
                    wc_d = '0;
                    if (kidx_q == nlast_q) begin
                        state_d = StGap;
                        gc_d    = '0;
                    end else begin
                        kidx_d = kidx_q + AW'(1);
                        dat_d  = dw_in;
                        addr_d = addr_q + AW'(1);
                    end
                end else begin
                    wc_d = wc_q + WcW'(1);
                end
            end
            StGap: begin
                if (gc_q == GcLast) begin
                    state_d = StIdle;
                end else begin
                    gc_d = gc_q + GcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only, so st never reaches an output combinationally
    always_comb begin
        txen     = 1'b0;
        DAT      = '0;
        sync_cw  = 1'b0;
        word_stb = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state_q)
            StIdle: busy = 1'b0;
            StCw: begin
                txen     = 1'b1;
                DAT      = CW_TX;
                sync_cw  = 1'b1;
                word_stb = (wc_q == '0);
            end
            StDw: begin
                txen     = 1'b1;
                DAT      = dat_q;
                word_stb = (wc_q == '0);
            end
            StGap: done = (gc_q == GcLast);
            default: busy = 1'b0;
        endcase
    end

    assign dw_addr = addr_q;

`ifdef ABORT_EN
    logic aborted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else if (state_q == StIdle && st) begin
            aborted_q <= 1'b0;
        end else if ((state_q == StCw || state_q == StDw) && abort) begin
            aborted_q <= 1'b1;
        end
    end

    assign aborted = aborted_q;
`endif

endmodule
